// File: rtl/int_controller_pkg.sv
// int_controller_pkg: register addresses, FSM encodings and CTRL bit positions
package int_controller_pkg;

   localparam logic [1:0] IC_MASK = 2'd0;
   localparam logic [1:0] IC_MODE = 2'd1;
   localparam logic [1:0] IC_PEND = 2'd2;
   localparam logic [1:0] IC_CTRL = 2'd3;

   localparam int IC_GE_BIT  = 31;
   localparam int IC_SVC_BIT = 30;

   typedef enum logic [1:0] {
      IC_IDLE    = 2'd0,
      IC_ASSERT  = 2'd1,
      IC_SERVICE = 2'd2
   } ic_state_e;

endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-first priority encoder with a valid flag
module int_prio_enc #(
   parameter int N_SRC = 8,
   parameter int ID_W  = 3
) (
   input  logic [N_SRC-1:0] req,
   output logic [ID_W-1:0]  id,
   output logic             valid
);

   // scan from the top down so the lowest set index is the last one written
   always_comb begin
      id    = '0;
      valid = |req;
      for (int i = N_SRC - 1; i >= 0; i--)
         if (req[i]) id = ID_W'(i);
   end

endmodule

// File: rtl/int_controller.sv
// int_controller: masked, edge/level, fixed-priority interrupt sequencer for the CPU INT line
module int_controller
   import int_controller_pkg::*;
#(
   parameter int N_SRC = 8,
   parameter int ID_W  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             int_ack,
   input  logic             eret,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [31:0]      cfg_wdata,
   output logic [31:0]      cfg_rdata,
   output logic             INT,
   output logic [ID_W-1:0]  cur_id,
   output logic             in_service
);

   ic_state_e        state_q, state_d;
   logic [N_SRC-1:0] mask_q, mask_d, mode_q, mode_d, pend_q, pend_d, prev_q;
   logic             ge_q, ge_d, int_q, int_d, svc_q, svc_d;
   logic [ID_W-1:0]  cur_id_q, cur_id_d, win_id;
   logic [N_SRC-1:0] pending, elig, w1c, ack_clr;
   logic             win_v, ack_take;
   logic             unused_wdata;

   // only the low N_SRC bits and the GE bit of write data are architectural
   assign unused_wdata = ^cfg_wdata;

   // level bits follow the pin; edge bits come from the sticky register
   assign pending = (pend_q & mode_q) | (irq_src & ~mode_q);
   assign elig    = ge_q ? (pending & mask_q) : '0;

   int_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio (
      .req   (elig),
      .id    (win_id),
      .valid (win_v)
   );

   // configuration writes and edge-pending bookkeeping; a new edge beats a same-cycle clear
   always_comb begin
      mask_d  = (cfg_we && cfg_addr == IC_MASK) ? cfg_wdata[N_SRC-1:0] : mask_q;
      mode_d  = (cfg_we && cfg_addr == IC_MODE) ? cfg_wdata[N_SRC-1:0] : mode_q;
      ge_d    = (cfg_we && cfg_addr == IC_CTRL) ? cfg_wdata[IC_GE_BIT] : ge_q;
      w1c     = (cfg_we && cfg_addr == IC_PEND) ? cfg_wdata[N_SRC-1:0] : '0;
      ack_clr = ack_take ? (N_SRC'(1) << win_id) : '0;
      pend_d  = ((pend_q & ~(w1c | ack_clr)) | (irq_src & ~prev_q)) & mode_q;
   end

   // IDLE -> ASSERT -> SERVICE handshake; losing eligibility in ASSERT takes priority over int_ack
   always_comb begin
      state_d  = state_q;
      cur_id_d = cur_id_q;
      ack_take = 1'b0;
      case (state_q)
         IC_IDLE:    state_d = win_v ? IC_ASSERT : IC_IDLE;
         IC_ASSERT: begin
            if (!win_v) state_d = IC_IDLE;
            else if (int_ack) begin
               state_d  = IC_SERVICE;
               cur_id_d = win_id;
               ack_take = 1'b1;
            end
         end
         IC_SERVICE: state_d = eret ? IC_IDLE : IC_SERVICE;
         default:    state_d = IC_IDLE;
      endcase
      int_d = (state_d == IC_ASSERT);
      svc_d = (state_d == IC_SERVICE);
   end

   // all architectural state, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IC_IDLE;
         mask_q   <= '0;
         mode_q   <= '0;
         pend_q   <= '0;
         prev_q   <= '0;
         ge_q     <= 1'b0;
         int_q    <= 1'b0;
         svc_q    <= 1'b0;
         cur_id_q <= '0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         mode_q   <= mode_d;
         pend_q   <= pend_d;
         prev_q   <= irq_src;
         ge_q     <= ge_d;
         int_q    <= int_d;
         svc_q    <= svc_d;
         cur_id_q <= cur_id_d;
      end
   end

   // register read mux; unimplemented bits stay zero
   always_comb begin
      cfg_rdata = 32'(cur_id_q);
      cfg_rdata[IC_SVC_BIT] = svc_q;
      cfg_rdata[IC_GE_BIT]  = ge_q;
      cfg_rdata = (cfg_addr == IC_MASK) ? 32'(mask_q) :
                  (cfg_addr == IC_MODE) ? 32'(mode_q) :
                  (cfg_addr == IC_PEND) ? 32'(pending) : cfg_rdata;
   end

   assign INT        = int_q;
   assign in_service = svc_q;
   assign cur_id     = cur_id_q;

endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed scenario tests for int_controller
module tb_int_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  irq_src = '0;
   logic        int_ack = 1'b0;
   logic        eret = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic [31:0] cfg_rdata;
   logic        int_o;
   logic [2:0]  cur_id;
   logic        in_service;

   int n_checks = 0;
   int n_fail   = 0;

   int_controller #(.N_SRC(8), .ID_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_src    (irq_src),
      .int_ack    (int_ack),
      .eret       (eret),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_rdata  (cfg_rdata),
      .INT        (int_o),
      .cur_id     (cur_id),
      .in_service (in_service)
   );

   always #10 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0; cfg_wdata = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      cfg_addr = a;
      #1 d = cfg_rdata;
   endtask

   task automatic pulse_ack;
      int_ack = 1'b1; @(negedge clk); int_ack = 1'b0;
   endtask

   task automatic pulse_eret;
      eret = 1'b1; @(negedge clk); eret = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset = 1'b1;
      cyc(2);
      n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL reset_int got=%b exp=0", int_o); end
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_svc got=%b exp=0", in_service); end
      n_checks++; if (cur_id !== 3'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", cur_id); end
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d got=%h exp=0", a, d); end
      end
      reset = 1'b0;
      cyc(1);
   endtask

   task automatic test_basic;
      logic [31:0] d;
      wr(2'd1, 32'h01);
      wr(2'd0, 32'h01);
      wr(2'd3, 32'h8000_0000);
      rd(2'd3, d);
      n_checks++; if (d !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_ctrl got=%h exp=80000000", d); end
      irq_src = 8'h01;
      cyc(1);
      n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL basic_lat1 got=%b exp=0", int_o); end
      cyc(1);
      n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL basic_lat2 got=%b exp=1", int_o); end
      pulse_ack;
      rd(2'd2, d);
      n_checks++; if (cur_id !== 3'd0) begin n_fail++; $display("FAIL basic_id got=%0d exp=0", cur_id); end
      n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL basic_svc got=%b exp=1", in_service); end
      n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL basic_int_svc got=%b exp=0", int_o); end
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL basic_pend got=%h exp=0", d); end
      rd(2'd3, d);
      n_checks++; if (d !== 32'hC000_0000) begin n_fail++; $display("FAIL basic_ctrl_svc got=%h exp=c0000000", d); end
      pulse_eret;
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL basic_eret got=%b exp=0", in_service); end
      cyc(1);
      n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle got=%b exp=0", int_o); end
      irq_src = 8'h00;
      cyc(1);
   endtask

   task automatic test_priority;
      logic [31:0] d;
      wr(2'd1, 32'hFF);
      wr(2'd0, 32'hFF);
      irq_src = 8'h24;
      cyc(2);
      n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL prio_int got=%b exp=1", int_o); end
      pulse_ack;
      irq_src = 8'h00;
      rd(2'd2, d);
      n_checks++; if (cur_id !== 3'd2) begin n_fail++; $display("FAIL prio_id1 got=%0d exp=2", cur_id); end
      n_checks++; if (d !== 32'h20) begin n_fail++; $display("FAIL prio_pend got=%h exp=20", d); end
      pulse_eret;
      n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got=%b exp=0", int_o); end
      cyc(1);
      n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL b2b_reassert got=%b exp=1", int_o); end
      pulse_ack;
      rd(2'd2, d);
      n_checks++; if (cur_id !== 3'd5) begin n_fail++; $display("FAIL prio_id2 got=%0d exp=5", cur_id); end
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL prio_pend2 got=%h exp=0", d); end
      pulse_eret;
      cyc(1);
   endtask

   task automatic test_level;
      logic [31:0] d;
      wr(2'd1, 32'h00);
      wr(2'd0, 32'h08);
      irq_src = 8'h08;
      cyc(1);
      n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL level_int got=%b exp=1", int_o); end
      wr(2'd0, 32'h00);
      cyc(1);
      rd(2'd2, d);
      n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL level_drop got=%b exp=0", int_o); end
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL level_svc got=%b exp=0", in_service); end
      n_checks++; if (d !== 32'h08) begin n_fail++; $display("FAIL level_pend got=%h exp=08", d); end
      wr(2'd2, 32'h08);
      rd(2'd2, d);
      n_checks++; if (d !== 32'h08) begin n_fail++; $display("FAIL level_w1c got=%h exp=08", d); end
      irq_src = 8'h00;
      cyc(1);
   endtask

   task automatic test_w1c_race;
      logic [31:0] d;
      wr(2'd1, 32'hFF);
      irq_src = 8'h10;
      cyc(1);
      irq_src = 8'h00;
      cyc(1);
      rd(2'd2, d);
      n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL w1c_setup got=%h exp=10", d); end
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h10; irq_src = 8'h10;
      @(negedge clk);
      cfg_we = 1'b0;
      rd(2'd2, d);
      n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL w1c_race got=%h exp=10", d); end
      wr(2'd2, 32'h00);
      rd(2'd2, d);
      n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL w1c_zero got=%h exp=10", d); end
      wr(2'd2, 32'h10);
      rd(2'd2, d);
      n_checks++; if (d !== 32'h00) begin n_fail++; $display("FAIL w1c_clear got=%h exp=00", d); end
      irq_src = 8'h00;
      cyc(1);
   endtask

   task automatic test_stray;
      pulse_ack;
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL stray_ack_svc got=%b exp=0", in_service); end
      n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL stray_ack_int got=%b exp=0", int_o); end
      n_checks++; if (cur_id !== 3'd5) begin n_fail++; $display("FAIL stray_ack_id got=%0d exp=5", cur_id); end
      wr(2'd0, 32'h02);
      irq_src = 8'h02;
      cyc(2);
      n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL stray_assert got=%b exp=1", int_o); end
      pulse_eret;
      n_checks++; if (int_o !== 1'b1) begin n_fail++; $display("FAIL stray_eret_int got=%b exp=1", int_o); end
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL stray_eret_svc got=%b exp=0", in_service); end
      n_checks++; if (cur_id !== 3'd5) begin n_fail++; $display("FAIL stray_eret_id got=%0d exp=5", cur_id); end
      int_ack = 1'b1; eret = 1'b1;
      @(negedge clk);
      int_ack = 1'b0; eret = 1'b0;
      n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL both_svc got=%b exp=1", in_service); end
      n_checks++; if (cur_id !== 3'd1) begin n_fail++; $display("FAIL both_id got=%0d exp=1", cur_id); end
      pulse_eret;
      irq_src = 8'h00;
      cyc(1);
   endtask

   task automatic test_async_reset;
      logic [31:0] d;
      wr(2'd0, 32'h40);
      irq_src = 8'h40;
      cyc(2);
      pulse_ack;
      n_checks++; if (cur_id !== 3'd6) begin n_fail++; $display("FAIL ar_setup_id got=%0d exp=6", cur_id); end
      n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL ar_setup_svc got=%b exp=1", in_service); end
      irq_src = 8'h00;
      #2 reset = 1'b1;
      #1;
      n_checks++; if (int_o !== 1'b0) begin n_fail++; $display("FAIL ar_int got=%b exp=0", int_o); end
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL ar_svc got=%b exp=0", in_service); end
      n_checks++; if (cur_id !== 3'd0) begin n_fail++; $display("FAIL ar_id got=%0d exp=0", cur_id); end
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ar_reg%0d got=%h exp=0", a, d); end
      end
      @(negedge clk);
      reset = 1'b0;
      cyc(1);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_priority;
      test_level;
      test_w1c_race;
      test_stray;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Programmable interrupt controller that sequences the pipeline CPU's single `INT` line and the CP0 `INT_ACK`/`eret` handshake.
- Collects up to N_SRC external requests and applies per-source mask and edge/level mode.
- Arbitrates by fixed priority and tracks one in-service interrupt until the handler executes `eret`.
- Configured by the CPU through a small memory-mapped register port on the MIO bus.

Parameters:
- N_SRC, 8, number of interrupt sources (2..32).
- ID_W, 3, width of the source ID; must satisfy 2^ID_W >= N_SRC.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_src  input  N_SRC  raw interrupt requests, already synchronous to clk.
- int_ack  input  1  one-cycle pulse from CP0 when the CPU takes the interrupt.
- eret  input  1  one-cycle pulse when eret retires; ends the current service.
- cfg_we  input  1  register write strobe.
- cfg_addr  input  2  register select.
- cfg_wdata  input  32  register write data.
- cfg_rdata  output  32  register read data, combinational from cfg_addr.
- INT  output  1  interrupt request to the CPU core.
- cur_id  output  ID_W  ID of the in-service source; valid in SERVICE.
- in_service  output  1  high while in the SERVICE state.

Behaviour:
- Register map:
  - 0 MASK: 1 = enabled, bits [N_SRC-1:0], R/W.
  - 1 MODE: 1 = edge, 0 = level, R/W.
  - 2 PENDING: read returns pending; write 1 clears an edge bit; write 0 has no effect.
  - 3 CTRL: bit31 = global enable GE (R/W); bits[ID_W-1:0] = cur_id (RO); bit30 = in_service (RO).
- Unused and unimplemented register bits read as 0.
- Pending, edge sources: the bit sets on a 0->1 transition of irq_src versus its value in the previous cycle. It clears by W1C, or when the source is acknowledged.
- Pending, level sources: the bit equals irq_src directly; W1C has no effect.
- Set and clear on the same bit in the same cycle: set wins.
- Eligible vector = PENDING & MASK, gated by GE.
- Winner = lowest-index eligible bit (fixed priority, source 0 highest).
- State machine (2-bit encoding):
  - IDLE → ASSERT when eligible != 0.
  - ASSERT: INT = 1.
    - eligible == 0 (masked, cleared, or GE = 0) → IDLE, with INT dropping in that same registered cycle.
    - int_ack → SERVICE. Latch the winner into cur_id on that edge; if that source is edge mode, clear its pending bit.
  - SERVICE: INT = 0, in_service = 1.
    - eret → IDLE.
    - No nesting: a higher-priority request only becomes pending.
- INT is a registered output. Latency: source edge at cycle N → pending set at N+1 → state ASSERT and INT high at N+2.
- Back-to-back: if eligible != 0 when eret arrives, INT re-asserts 2 cycles after eret (IDLE for one cycle).
- Ignored events:
  - int_ack in IDLE or SERVICE.
  - eret in IDLE or ASSERT.
  - int_ack and eret together in ASSERT → int_ack wins.
- Winner is resampled each cycle in ASSERT; the ID latched is the winner at the int_ack edge.
- A level source deasserting during SERVICE does not abort service.
- Reset (async, any state):
  - state = IDLE; INT = 0; in_service = 0; cur_id = 0.
  - MASK = 0, MODE = 0, PENDING = 0, GE = 0, previous-sample register = 0.
  - Operation resumes normally on the first clock after reset release.

Decomposition:
- Shared constants in the global define header: register addresses (IC_MASK, IC_MODE, IC_PEND, IC_CTRL), state encodings (IC_IDLE, IC_ASSERT, IC_SERVICE), GE bit index.
- One sub-module, int_prio_enc: combinational N_SRC → ID_W lowest-index priority encoder with a valid flag.

Test Plan:
- Reset, then MASK = 0x01, GE = 1, irq_src[0] 0→1 at cycle 10 → INT = 1 at cycle 12.
  - Pulse int_ack → cur_id = 0, in_service = 1, PENDING = 0x00, INT = 0.
  - Pulse eret → IDLE.
- MASK = 0xFF, MODE = 0xFF, edges on sources 5 and 2 in the same cycle → int_ack yields cur_id = 2, PENDING = 0x20.
  - After eret → INT re-asserts 2 cycles later; next int_ack yields cur_id = 5.
- Level source 3 with MASK = 0x08 held high in ASSERT, then CPU writes MASK = 0 → INT drops next cycle, state IDLE, PENDING bit 3 still reads 1.
- W1C of PENDING bit 4 in the same cycle as a new edge on source 4 → PENDING bit 4 reads 1.
- Stray pulses: int_ack in IDLE, eret in ASSERT → no state change, INT unchanged, cur_id unchanged.
- Async reset asserted mid-SERVICE (cur_id = 6) → INT, in_service, cur_id and all registers read 0 immediately, without waiting for a clock edge.
